mul_ctrl: RTL and testbench

Sequential shift-and-add multiply controller for the non-pipelined Harvard CPU. It accepts two 16-bit register operands on a start strobe and iterates one multiplier bit per cycle to form the full 32-bit product. It supports signed and unsigned operation and signals completion with a one-cycle done pulse. The core's stall logic holds the pipeline on `busy` and writes `q_lo` (MUL) or `q_hi` (MULH) back on `done`.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_shift_add_dp.sv | 66 ++++++
 rtl/mul_ctrl.sv | 116 +++++++++++
 tb/tb_mul_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // Magnitude as an unsigned value; 0x8000 maps to itself without overflow.
    function automatic logic [MUL_W-1:0] abs_val(input logic [MUL_W-1:0] v, input logic sgn);
        return (sgn && v[MUL_W-1]) ? (~v + MUL_W'(1)) : v;
    endfunction

    function automatic logic [2*MUL_W-1:0] neg_prod(input logic [2*MUL_W-1:0] v);
        return ~v + (2*MUL_W)'(1);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-and-add datapath: operand magnitudes, accumulator/multiplier shift pair,
// sign fix-up and the registered result halves.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             step,
    input  logic             fix,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] q_lo,
    output logic [WIDTH-1:0] q_hi
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // The low product half shifts in behind the consumed multiplier bits.
    always_comb begin
        sum = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};
    end

    assign prod     = {acc_hi, mplier};
    assign prod_fix = neg ? neg_prod(prod) : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc_hi <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            q_lo   <= '0;
            q_hi   <= '0;
        end else begin
            if (load) begin
                mcand  <= abs_val(rs, signed_op);
                mplier <= abs_val(rd, signed_op);
                acc_hi <= '0;
                neg    <= signed_op & (rs[WIDTH-1] ^ rd[WIDTH-1]);
            end else if (step) begin
                acc_hi <= sum[WIDTH:1];
                mplier <= {sum[0], mplier[WIDTH-1:1]};
            end

            if (clear) begin
                q_hi <= '0;
                q_lo <= '0;
            end else if (fix) begin
                q_hi <= prod_fix[2*WIDTH-1:WIDTH];
                q_lo <= prod_fix[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// Multiply controller: sequences the shift-and-add datapath, one multiplier bit per cycle.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one shift-and-add iteration per cycle, cnt counts iterations
//   FIX   | apply sign, load q_hi/q_lo
//   DONE  | done pulse; a start here launches the next operation directly
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_lo,
    output logic [WIDTH-1:0] q_hi
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state;
    mul_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             op_zero;
    logic             load;
    logic             clear;
    logic             step;
    logic             fix;

    assign op_zero = (rs == '0) || (rd == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    if (op_zero) begin
                        clear    = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        load     = 1'b1;
                        state_nx = ST_RUN;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                fix      = 1'b1;
                state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // busy/done registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            busy <= (state_nx == ST_RUN) || (state_nx == ST_FIX);
            done <= (state_nx == ST_DONE);
        end
    end

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .clear    (clear),
        .step     (step),
        .fix      (fix),
        .signed_op(signed_op),
        .rs       (rs),
        .rd       (rd),
        .q_lo     (q_lo),
        .q_hi     (q_hi)
    );

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed vector table, multi-cycle hazard
// sequences and randomized operations against an arithmetic reference.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [15:0] rs;
    logic [15:0] rd;
    logic        busy;
    logic        done;
    logic [15:0] q_lo;
    logic [15:0] q_hi;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] prev_hi = '0;
    logic [15:0] prev_lo = '0;

    always #5 clk = ~clk;

    mul_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_op(signed_op),
        .rs       (rs),
        .rd       (rd),
        .busy     (busy),
        .done     (done),
        .q_lo     (q_lo),
        .q_hi     (q_hi)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] hi;
        logic [15:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        rs = a;
        rd = b;
        signed_op = s;
        start = 1'b1;
    endtask

    // Waits for done; scrambles operands once start drops to prove they are not re-sampled.
    task automatic wait_done(output int lat, output int bcnt, output bit hold_ok, output bit to);
        lat = 0;
        bcnt = 0;
        hold_ok = 1'b1;
        to = 1'b0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                start = 1'b0;
                rs = 16'($urandom);
                rd = 16'($urandom);
                signed_op = 1'($urandom);
            end
            lat++;
            if (busy) bcnt++;
            if (!done && (q_hi !== prev_hi || q_lo !== prev_lo)) hold_ok = 1'b0;
        end while (!done && lat < 40);
        if (!done) to = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] ehi, input logic [15:0] elo);
        int lat, bcnt;
        bit hold_ok, to;
        bit zero;
        zero = (a == 16'h0) || (b == 16'h0);
        launch(a, b, s);
        wait_done(lat, bcnt, hold_ok, to);
        chk({tag, " timeout"}, 32'(to), 32'd0);
        chk({tag, " q_hi"}, 32'(q_hi), 32'(ehi));
        chk({tag, " q_lo"}, 32'(q_lo), 32'(elo));
        chk({tag, " latency"}, 32'(lat), zero ? 32'd1 : 32'd18);
        chk({tag, " busy_cycles"}, 32'(bcnt), zero ? 32'd0 : 32'd17);
        chk({tag, " q_hold"}, 32'(hold_ok), 32'd1);
        prev_hi = ehi;
        prev_lo = elo;
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat, bcnt;
        bit hold_ok, to, no_done;
        logic [15:0] a, b;
        logic s;
        logic [31:0] p;

        vecs.push_back('{16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001});
        vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 16'hFFFF, 16'hFFF1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'hFFFF, 16'h8000});
        vecs.push_back('{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000});
        vecs.push_back('{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001});
        vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 16'hC000, 16'h8000});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h4000, 16'h0000});

        rst = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        rs = '0;
        rd = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset q_hi", 32'(q_hi), 32'd0);
        chk("reset q_lo", 32'(q_lo), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hi, vecs[i].lo);
        end

        // start pulsed mid-RUN with new operands must be ignored
        launch(16'h0123, 16'h0045, 1'b0);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        rs = 16'hFFFF;
        rd = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("midrun latency", 32'(lat), 32'd18);
        chk("midrun result", {q_hi, q_lo}, 32'h0000_4E6F);
        repeat (2) @(negedge clk);
        chk("midrun no_requeue busy", 32'(busy), 32'd0);
        chk("midrun no_requeue done", 32'(done), 32'd0);
        prev_hi = 16'h0000;
        prev_lo = 16'h4E6F;

        // start held in the DONE cycle launches the next op with no IDLE gap
        launch(16'h00FF, 16'h0101, 1'b0);
        wait_done(lat, bcnt, hold_ok, to);
        chk("b2b first latency", 32'(lat), 32'd18);
        chk("b2b first result", {q_hi, q_lo}, 32'h0000_FFFF);
        prev_hi = 16'h0000;
        prev_lo = 16'hFFFF;
        rs = 16'hFFFE;
        rd = 16'h0003;
        signed_op = 1'b1;
        start = 1'b1;
        wait_done(lat, bcnt, hold_ok, to);
        chk("b2b second timeout", 32'(to), 32'd0);
        chk("b2b second latency", 32'(lat), 32'd18);
        chk("b2b second busy_cycles", 32'(bcnt), 32'd17);
        chk("b2b second result", {q_hi, q_lo}, 32'hFFFF_FFFA);
        chk("b2b q_hold", 32'(hold_ok), 32'd1);

        // reset during RUN aborts with no done
        launch(16'h00AB, 16'h00CD, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort q", {q_hi, q_lo}, 32'd0);
        rst = 1'b0;
        no_done = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) no_done = 1'b0;
        end
        chk("abort stays idle", 32'(no_done), 32'd1);
        prev_hi = '0;
        prev_lo = '0;
        run_op("post_abort 7*9", 16'h0007, 16'h0009, 1'b0, 16'h0000, 16'h003F);

        // randomized operations against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: a = 16'h0000;
                1: a = 16'h8000;
                2: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'h7FFF;
                default: b = 16'($urandom);
            endcase
            s = 1'($urandom);
            p = ref_prod(a, b, s);
            run_op($sformatf("rand%0d %h*%h s=%0d", i, a, b, s), a, b, s, p[31:16], p[15:0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
